// File: rtl/karatsuba8_pkg.sv
// Shared definitions for the 8x8 Karatsuba multiplier control unit and datapath.
//   state_t       : control-unit state encoding (binary, IDLE = 0)
//   MUL_*         : multiplier operand select codes (mul_sel)
//   SS_*          : adder/subtractor operand select codes (ss_sel)
package karatsuba8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_S6   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic [1:0] MUL_LL = 2'b00;  // Xl * Yl
    localparam logic [1:0] MUL_HH = 2'b01;  // Xh * Yh
    localparam logic [1:0] MUL_CD = 2'b10;  // C[4:0] * D

    localparam logic [2:0] SS_XSUM = 3'b000;  // Xh + Xl
    localparam logic [2:0] SS_YSUM = 3'b001;  // Yh + Yl
    localparam logic [2:0] SS_AB   = 3'b010;  // A +/- B
    localparam logic [2:0] SS_CE   = 3'b011;  // C +/- E
    localparam logic [2:0] SS_AB8  = 3'b100;  // A +/- (B << 8)
    localparam logic [2:0] SS_AC4  = 3'b101;  // A +/- (C << 4)

endpackage

// File: rtl/karatsuba8_uc.sv
// Control unit for the 8x8 Karatsuba multiplier datapath.
// Sequences one multiply in seven cycles (S1..S6, DONE):
//   S1 A<-z0, C<-Xh+Xl   S2 B<-z2, D<-Yh+Yl   S3 C<-C*D, E<-z0+z2
//   S4 C<-C-E (z1)       S5 A<-A+(z1<<4)      S6 A<-A+(z2<<8)
// Ports:
//   clk, rst (async, active-low)   start       : multiply request, X/Y valid
//   busy (S1..S6), done (DONE)     x_ld, y_ld  : operand register loads
//   a_ld..e_ld : datapath register loads       sub : subtract select
//   a_sel, c_sel : 0 = multiplier, 1 = adder   mul_sel, ss_sel : operand muxes
// DONE_HOLD = 0 pulses done for one cycle; 1 holds it until the next start.
module karatsuba8_uc
    import karatsuba8_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       x_ld,
    output logic       y_ld,
    output logic       a_ld,
    output logic       b_ld,
    output logic       c_ld,
    output logic       d_ld,
    output logic       e_ld,
    output logic       sub,
    output logic       a_sel,
    output logic       c_sel,
    output logic [1:0] mul_sel,
    output logic [2:0] ss_sel
);

    state_t state, state_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        x_ld     = 1'b0;
        y_ld     = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        c_ld     = 1'b0;
        d_ld     = 1'b0;
        e_ld     = 1'b0;
        sub      = 1'b0;
        a_sel    = 1'b0;
        c_sel    = 1'b0;
        mul_sel  = MUL_LL;
        ss_sel   = SS_XSUM;

        // x_ld/y_ld are Mealy on start; gating with rst keeps every output
        // at its reset value while reset is held, even if start is high.
        if (rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_ld     = 1'b1;
                        y_ld     = 1'b1;
                        state_nx = ST_S1;
                    end
                end
                ST_S1: begin
                    busy     = 1'b1;
                    mul_sel  = MUL_LL;
                    a_sel    = 1'b0;
                    a_ld     = 1'b1;
                    ss_sel   = SS_XSUM;
                    c_sel    = 1'b1;
                    c_ld     = 1'b1;
                    state_nx = ST_S2;
                end
                ST_S2: begin
                    busy     = 1'b1;
                    mul_sel  = MUL_HH;
                    b_ld     = 1'b1;
                    ss_sel   = SS_YSUM;
                    d_ld     = 1'b1;
                    state_nx = ST_S3;
                end
                ST_S3: begin
                    busy     = 1'b1;
                    mul_sel  = MUL_CD;
                    c_sel    = 1'b0;
                    c_ld     = 1'b1;
                    ss_sel   = SS_AB;
                    sub      = 1'b0;
                    e_ld     = 1'b1;
                    state_nx = ST_S4;
                end
                ST_S4: begin
                    busy     = 1'b1;
                    ss_sel   = SS_CE;
                    sub      = 1'b1;
                    c_sel    = 1'b1;
                    c_ld     = 1'b1;
                    state_nx = ST_S5;
                end
                ST_S5: begin
                    busy     = 1'b1;
                    ss_sel   = SS_AC4;
                    a_sel    = 1'b1;
                    a_ld     = 1'b1;
                    state_nx = ST_S6;
                end
                ST_S6: begin
                    busy     = 1'b1;
                    ss_sel   = SS_AB8;
                    a_sel    = 1'b1;
                    a_ld     = 1'b1;
                    state_nx = ST_DONE;
                end
                ST_DONE: begin
                    done = 1'b1;
                    if (start) begin
                        x_ld     = 1'b1;
                        y_ld     = 1'b1;
                        state_nx = ST_S1;
                    end else if (DONE_HOLD) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba8_uc.sv
// Bench for karatsuba8_uc: two instances (DONE_HOLD = 0 and 1), a behavioural
// datapath driven by the instance-0 controls, and X*Y as the reference result.
module tb_karatsuba8_uc;

    logic       clk;
    logic       rst;
    logic       start0, start1;
    logic [7:0] x_in, y_in;

    logic       busy0, done0, x_ld0, y_ld0, a_ld0, b_ld0, c_ld0, d_ld0, e_ld0;
    logic       sub0, a_sel0, c_sel0;
    logic [1:0] mul_sel0;
    logic [2:0] ss_sel0;

    logic       busy1, done1, x_ld1, y_ld1, a_ld1, b_ld1, c_ld1, d_ld1, e_ld1;
    logic       sub1, a_sel1, c_sel1;
    logic [1:0] mul_sel1;
    logic [2:0] ss_sel1;

    int n_checks = 0;
    int n_pass   = 0;

    karatsuba8_uc #(.DONE_HOLD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x_ld(x_ld0), .y_ld(y_ld0), .a_ld(a_ld0), .b_ld(b_ld0), .c_ld(c_ld0),
        .d_ld(d_ld0), .e_ld(e_ld0), .sub(sub0), .a_sel(a_sel0), .c_sel(c_sel0),
        .mul_sel(mul_sel0), .ss_sel(ss_sel0)
    );

    karatsuba8_uc #(.DONE_HOLD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .x_ld(x_ld1), .y_ld(y_ld1), .a_ld(a_ld1), .b_ld(b_ld1), .c_ld(c_ld1),
        .d_ld(d_ld1), .e_ld(e_ld1), .sub(sub1), .a_sel(a_sel1), .c_sel(c_sel1),
        .mul_sel(mul_sel1), .ss_sel(ss_sel1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural datapath driven by the dut0 control outputs.
    logic [7:0]  mx, my;
    logic [15:0] ma, mb;
    logic [9:0]  mc;
    logic [4:0]  md;
    logic [8:0]  me;

    function automatic int mul_val();
        case (mul_sel0)
            2'b00:   return int'(mx[3:0]) * int'(my[3:0]);
            2'b01:   return int'(mx[7:4]) * int'(my[7:4]);
            2'b10:   return int'(mc[4:0]) * int'(md);
            default: return 0;
        endcase
    endfunction

    function automatic int ss_val();
        int p, q;
        case (ss_sel0)
            3'b000:  begin p = int'(mx[7:4]); q = int'(mx[3:0]); end
            3'b001:  begin p = int'(my[7:4]); q = int'(my[3:0]); end
            3'b010:  begin p = int'(ma);      q = int'(mb);      end
            3'b011:  begin p = int'(mc);      q = int'(me);      end
            3'b100:  begin p = int'(ma);      q = int'(mb) << 8; end
            3'b101:  begin p = int'(ma);      q = int'(mc) << 4; end
            default: begin p = 0;             q = 0;             end
        endcase
        return sub0 ? p - q : p + q;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx <= '0; my <= '0; ma <= '0; mb <= '0; mc <= '0; md <= '0; me <= '0;
        end else begin
            if (x_ld0) mx <= x_in;
            if (y_ld0) my <= y_in;
            if (a_ld0) ma <= a_sel0 ? 16'(ss_val()) : 16'(mul_val());
            if (b_ld0) mb <= 16'(mul_val());
            if (c_ld0) mc <= c_sel0 ? 10'(ss_val()) : 10'(mul_val());
            if (d_ld0) md <= 5'(ss_val());
            if (e_ld0) me <= 9'(ss_val());
        end
    end

    // {busy,done,x_ld,y_ld,a_ld,b_ld,c_ld,d_ld,e_ld,sub,a_sel,c_sel,mul_sel,ss_sel}
    function automatic logic [16:0] pk(input logic bz, dn, xl, yl, al, bl, cl, dl, el,
                                       input logic sb, as, cs, input logic [1:0] ms,
                                       input logic [2:0] ss);
        return {bz, dn, xl, yl, al, bl, cl, dl, el, sb, as, cs, ms, ss};
    endfunction

    function automatic logic [16:0] vec0();
        return {busy0, done0, x_ld0, y_ld0, a_ld0, b_ld0, c_ld0, d_ld0, e_ld0,
                sub0, a_sel0, c_sel0, mul_sel0, ss_sel0};
    endfunction

    function automatic logic [16:0] vec1();
        return {busy1, done1, x_ld1, y_ld1, a_ld1, b_ld1, c_ld1, d_ld1, e_ld1,
                sub1, a_sel1, c_sel1, mul_sel1, ss_sel1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [16:0] seq_tab [7];

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] r;
        int          pulse_at;
    } vec_t;

    vec_t vtab [5];

    task automatic do_mul(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_r, input int pulse_at, input string tag);
        @(posedge clk); #1;
        x_in = x; y_in = y; start0 = 1'b1;
        @(negedge clk);
        chk({tag, "/accept"}, 32'(vec0()), 32'(pk(0,0,1,1,0,0,0,0,0,0,0,0,2'b00,3'b000)));
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            if (k == pulse_at) begin
                start0 = 1'b1;
                x_in   = 8'($urandom);
                y_in   = 8'($urandom);
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("%s/cyc%0d", tag, k + 1), 32'(vec0()), 32'(seq_tab[k]));
            if (k == 6) chk({tag, "/R"}, 32'(ma), 32'(exp_r));
            if (k < 6) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk({tag, "/idle_after"}, 32'({busy0, done0}), 32'd0);
    endtask

    // Counts cycles (from the current one) until done rises on the chosen instance.
    task automatic wait_done(input bit which, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if ((which ? done1 : done0) === 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        logic [7:0] rx, ry;

        seq_tab[0] = pk(1,0,0,0,1,0,1,0,0,0,0,1,2'b00,3'b000);
        seq_tab[1] = pk(1,0,0,0,0,1,0,1,0,0,0,0,2'b01,3'b001);
        seq_tab[2] = pk(1,0,0,0,0,0,1,0,1,0,0,0,2'b10,3'b010);
        seq_tab[3] = pk(1,0,0,0,0,0,1,0,0,1,0,1,2'b00,3'b011);
        seq_tab[4] = pk(1,0,0,0,1,0,0,0,0,0,1,0,2'b00,3'b101);
        seq_tab[5] = pk(1,0,0,0,1,0,0,0,0,0,1,0,2'b00,3'b100);
        seq_tab[6] = pk(0,1,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000);

        vtab[0] = '{8'h0F, 8'h0F, 16'h00E1, -1};
        vtab[1] = '{8'hFF, 8'hFF, 16'hFE01, -1};
        vtab[2] = '{8'hA3, 8'h5C, 16'h3A94,  2};
        vtab[3] = '{8'h10, 8'h10, 16'h0100, -1};
        vtab[4] = '{8'h00, 8'h7B, 16'h0000, -1};

        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; x_in = '0; y_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/dut0", 32'(vec0()), 32'd0);
        chk("reset/dut1", 32'(vec1()), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle/dut0", 32'(vec0()), 32'd0);

        for (int i = 0; i < 5; i++)
            do_mul(vtab[i].x, vtab[i].y, vtab[i].r, vtab[i].pulse_at, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            do_mul(rx, ry, 16'(int'(rx) * int'(ry)), -1, $sformatf("rnd%0d", i));
        end

        // Start held high: DONE hands straight over to S1.
        @(posedge clk); #1;
        x_in = 8'h00; y_in = 8'h7B; start0 = 1'b1;
        @(posedge clk); #1;
        x_in = 8'h12; y_in = 8'h34;
        wait_done(1'b0, n);
        chk("b2b/lat1", 32'(n), 32'd7);
        chk("b2b/R1", 32'(ma), 32'h0000);
        chk("b2b/reaccept", 32'({x_ld0, y_ld0}), 32'd3);
        @(posedge clk); #1;
        wait_done(1'b0, n);
        chk("b2b/lat2", 32'(n), 32'd7);
        chk("b2b/R2", 32'(ma), 32'h03A8);
        start0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b/idle", 32'(vec0()), 32'd0);

        // Asynchronous reset in the middle of S4.
        @(posedge clk); #1;
        x_in = 8'h55; y_in = 8'hAA; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid/in_s4", 32'(vec0()), 32'(seq_tab[3]));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid/outs", 32'(vec0()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/stays_idle", 32'(vec0()), 32'd0);
        do_mul(8'h10, 8'h10, 16'h0100, -1, "post_rst");

        // DONE_HOLD = 1 instance.
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1'b1, n);
        chk("hold/lat", 32'(n), 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold/idle%0d", i), 32'({busy1, done1}), 32'b01);
        end
        @(posedge clk); #1;
        start1 = 1'b1;
        @(negedge clk);
        chk("hold/accept", 32'({done1, x_ld1, y_ld1}), 32'b111);
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        chk("hold/restart", 32'({busy1, done1}), 32'b10);
        @(posedge clk); #1;
        wait_done(1'b1, n);
        chk("hold/lat2", 32'(n), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
